uart2_rx: RTL and testbench

//  UART receiver: 8N1, LSB first, 1 start bit, 1 stop bit; companion to uart2_tx on the serial link.

---
 rtl/uart2_rx.sv | 155 +++++++++++++++
 tb/tb_uart2_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart2_rx.sv
// uart2_rx: 8N1 UART receiver, LSB first, mid-bit sampling, framing-error and break handling.
// Ports:
//   clock     - system clock, all logic on posedge
//   reset     - asynchronous active-high reset
//   rx_in     - serial line (idle high), asynchronous to clock
//   rx_out    - last correctly framed byte, held until the next good frame
//   rx_done   - one-cycle pulse when rx_out is updated
//   frame_err - one-cycle pulse when the stop bit is sampled low (byte discarded)
//   rx_busy   - high whenever the receiver is not idle
module uart2_rx #(
    parameter int unsigned CPB      = 868,
    parameter int unsigned half_CPB = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  rx_out_q, rx_out_d;
    logic               rx_done_q, rx_done_d;
    logic               frame_err_q, frame_err_d;
    logic               rx_busy_q, rx_busy_d;
    logic               rx_s;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_out_q    <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_out_q    <= rx_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    // Next-state and output logic; the counter restarts from zero on every transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_out_d    = rx_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(half_CPB)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(CPB)) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_W'(CPB)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_out_d  = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must not re-arm; wait for idle-high first.
                if (rx_s) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    assign rx_out    = rx_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart2_rx.sv
// tb_uart2_rx: directed bench for uart2_rx with a queue-based scoreboard and a decoupled monitor.
module tb_uart2_rx;

    localparam int unsigned CPB      = 15;
    localparam int unsigned HALF_CPB = 7;
    localparam int          BITP     = 16;
    localparam int          FRAME    = 10 * BITP;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_ferr   = 0;

    uart2_rx #(.CPB(CPB), .half_CPB(HALF_CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_out    (rx_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    // Line level at cycle offset o of a frame. In narrow mode each data bit holds its true
    // value only on the single cycle that the receiver should sample, inverted elsewhere.
    function automatic logic frame_bit(input logic [7:0] b, input logic stop_bit,
                                       input bit narrow, input int o);
        int k;
        logic v;
        if (o < BITP) return 1'b0;
        if (o >= 9 * BITP) return stop_bit;
        k = o / BITP - 1;
        v = b[k];
        if (narrow && (o != (HALF_CPB + 1) + (k + 1) * BITP)) v = ~v;
        return v;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit narrow);
        exp_t e;
        e.is_err = ~stop_bit;
        e.data   = b;
        exp_q.push_back(e);
        for (int o = 0; o < FRAME; o++) begin
            rx_in = frame_bit(b, stop_bit, narrow, o);
            tick();
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && (rx_done || frame_err)) begin
                check("done_and_err_exclusive", int'(rx_done & frame_err), 0);
                if (rx_done) n_done++;
                if (frame_err) n_ferr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_is_err", int'(frame_err), int'(e.is_err));
                    if (rx_done) check("rx_out_byte", int'(rx_out), int'(e.data));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) tick();
        check("reset_rx_out", int'(rx_out), 0);
        check("reset_rx_done", int'(rx_done), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        reset = 1'b0;
        idle(5);

        // Single byte, then the same byte with one-cycle-wide data bits to pin the sample clock
        send_frame(8'h96, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h96, 1'b1, 1'b1);
        idle(10);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(10);
        check("b2b_last_rx_out", int'(rx_out), 8'h55);

        // Short low glitch: START aborts at mid-bit
        rx_in = 1'b0;
        repeat (4) tick();
        rx_in = 1'b1;
        repeat (2) tick();
        check("glitch_busy_high", int'(rx_busy), 1);
        idle(14);
        check("glitch_busy_low", int'(rx_busy), 0);
        check("glitch_rx_out_kept", int'(rx_out), 8'h55);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        send_frame(8'hA5, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (40) tick();
        check("break_busy_high", int'(rx_busy), 1);
        check("break_rx_out_kept", int'(rx_out), 8'h3C);
        idle(6);
        check("break_busy_low", int'(rx_busy), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);

        // Reset in the middle of data bit 4
        for (int o = 0; o < 5 * BITP + 8; o++) begin
            rx_in = frame_bit(8'h5A, 1'b1, 1'b0, o);
            tick();
        end
        check("pre_reset_busy", int'(rx_busy), 1);
        reset = 1'b1;
        #1;
        check("midreset_rx_out", int'(rx_out), 0);
        check("midreset_rx_done", int'(rx_done), 0);
        check("midreset_frame_err", int'(frame_err), 0);
        check("midreset_rx_busy", int'(rx_busy), 0);
        rx_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        idle(5);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(20);

        check("final_rx_out", int'(rx_out), 8'hC3);
        check("queue_drained", exp_q.size(), 0);
        check("total_rx_done", n_done, 8);
        check("total_frame_err", n_ferr, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
